fifo_arbiter_rr: RTL and testbench

Round-robin scheduler between four input FIFOs and four output FIFOs of the same 10-bit FIFO type.
- Picks a non-empty input FIFO, pops one word, and routes it to the output FIFO named by the word's destination field.
- Honours each output FIFO's almost_full.
- Sits between the ingress FIFO bank and the egress FIFO bank. It is the only block driving their read_enable / write_enable.

---
 rtl/fifo_arbiter_rr_pkg.sv | 27 ++
 rtl/fifo_arbiter_rr_rr_grant.sv | 31 +++
 rtl/fifo_arbiter_rr.sv | 124 ++++++++++++
 tb/tb_fifo_arbiter_rr.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arbiter_rr_pkg.sv
// Shared definitions for the round-robin FIFO scheduler: FSM encoding, port count, word layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_arbiter_rr_pkg;

    // Number of ingress and egress FIFOs; the grant width below assumes exactly four.
    localparam int NUM_PORTS = 4;

    // Default word width; the top two bits of a word carry the destination FIFO index.
    localparam int TAMANO_DATOS_DEF = 10;
    localparam int DEST_W           = 2;

    // Consecutive stalled SEND cycles tolerated before the sticky error flag rises.
    localparam int STALL_MAX_DEF = 16;

    // FSM encoding, kept as plain constants so older tools can consume the package.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_READ    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_SEND    = 2'd3;

    // Index -> one-hot strobe for a four-port bank.
    function automatic logic [NUM_PORTS-1:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/fifo_arbiter_rr_rr_grant.sv
// Round-robin pick: first requester strictly after last_grant, wrapping modulo four.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is consumed.
module fifo_arbiter_rr_rr_grant
    import fifo_arbiter_rr_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           last_grant,
    output logic                 valid,
    output logic [1:0]           g
);

    logic [1:0] idx;
    logic       found;

    // Scan last_grant+1, +2, +3, +4 so the previous winner has the lowest priority.
    always_comb begin
        g     = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = last_grant + 2'(k);
            if (!found && req[idx]) begin
                g     = idx;
                found = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/fifo_arbiter_rr.sv
// Moves one word at a time from four ingress FIFOs to four egress FIFOs, round-robin over sources.
// Latency: 4 cycles per word minimum (IDLE pick, READ pop, CAPTURE data, SEND push).
// Backpressure: holds in SEND while the destination's almost_full is high; sticky error after stall_max stalls.
module fifo_arbiter_rr
    import fifo_arbiter_rr_pkg::*;
#(
    parameter int tamano_datos = TAMANO_DATOS_DEF,
    parameter int stall_max    = STALL_MAX_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          in_empty,
    input  logic [NUM_PORTS*tamano_datos-1:0] in_data,
    output logic [NUM_PORTS-1:0]          in_pop,
    input  logic [NUM_PORTS-1:0]          out_almost_full,
    output logic [NUM_PORTS-1:0]          out_push,
    output logic [tamano_datos-1:0]       out_data,
    output logic [1:0]                    grant,
    output logic                          idle,
    output logic                          error
);

    localparam int                DEST_LSB = tamano_datos - DEST_W;
    localparam int                CNT_W    = $clog2(stall_max + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(stall_max);

    logic [1:0]              state_q, state_d;
    logic [1:0]              grant_q, grant_d;
    logic [1:0]              last_grant_q, last_grant_d;
    logic [NUM_PORTS-1:0]    in_pop_q, in_pop_d;
    logic [tamano_datos-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
    logic                    error_q, error_d;

    logic [NUM_PORTS-1:0]    req;
    logic                    rr_valid;
    logic [1:0]              rr_g;
    logic [DEST_W-1:0]       dest;

    assign req  = ~in_empty;
    assign dest = hold_q[tamano_datos-1:DEST_LSB];

    fifo_arbiter_rr_rr_grant u_rr_grant (
        .req        (req),
        .last_grant (last_grant_q),
        .valid      (rr_valid),
        .g          (rr_g)
    );

    // Next-state logic; out_push is the only output that looks at an input (the egress almost_full).
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        in_pop_d     = in_pop_q;
        hold_d       = hold_q;
        stall_cnt_d  = stall_cnt_q;
        error_d      = error_q;
        out_push     = '0;
        case (state_q)
            ST_IDLE: begin
                if (rr_valid) begin
                    grant_d  = rr_g;
                    in_pop_d = onehot4(rr_g);
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                // The pop strobe lives for this single cycle; data appears next cycle.
                in_pop_d = '0;
                state_d  = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                hold_d  = in_data[int'(grant_q)*tamano_datos +: tamano_datos];
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!out_almost_full[dest]) begin
                    out_push     = onehot4(dest);
                    last_grant_d = grant_q;
                    stall_cnt_d  = '0;
                    state_d      = ST_IDLE;
                end else begin
                    if (stall_cnt_q != CNT_MAX) begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                    // Flag only; the word keeps waiting for space.
                    if (stall_cnt_d == CNT_MAX) begin
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; last_grant resets to 3 so FIFO 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd3;
            in_pop_q     <= '0;
            hold_q       <= '0;
            stall_cnt_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            in_pop_q     <= in_pop_d;
            hold_q       <= hold_d;
            stall_cnt_q  <= stall_cnt_d;
            error_q      <= error_d;
        end
    end

    assign in_pop   = in_pop_q;
    assign out_data = hold_q;
    assign grant    = grant_q;
    assign idle     = (state_q == ST_IDLE);
    assign error    = error_q;

endmodule

// File: tb/tb_fifo_arbiter_rr.sv
// Bench for fifo_arbiter_rr: behavioural ingress FIFOs, directed vectors and corner-case sequences.
// Latency: n/a.
// Backpressure: driven directly through out_almost_full.
module tb_fifo_arbiter_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_empty;
    logic [39:0] in_data;
    logic [3:0]  in_pop;
    logic [3:0]  out_almost_full;
    logic [3:0]  out_push;
    logic [9:0]  out_data;
    logic [1:0]  grant;
    logic        idle;
    logic        error;

    fifo_arbiter_rr #(.tamano_datos(10), .stall_max(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_empty        (in_empty),
        .in_data         (in_data),
        .in_pop          (in_pop),
        .out_almost_full (out_almost_full),
        .out_push        (out_push),
        .out_data        (out_data),
        .grant           (grant),
        .idle            (idle),
        .error           (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Ingress FIFO model: registered data_out, one cycle after read_enable.
    logic [9:0] fmem [4][16];
    int         fwr [4];
    int         frd [4];
    logic [9:0] fdout [4];

    initial begin
        for (int i = 0; i < 4; i++) begin
            fwr[i]   = 0;
            frd[i]   = 0;
            fdout[i] = 10'd0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (in_pop[i] && (fwr[i] != frd[i])) begin
                fdout[i] <= fmem[i][frd[i] % 16];
                frd[i]   <= frd[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_empty[i]          = (fwr[i] == frd[i]);
            in_data[i*10 +: 10]  = fdout[i];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int i, input logic [9:0] w);
        fmem[i][fwr[i] % 16] = w;
        fwr[i] = fwr[i] + 1;
    endtask

    task automatic wait_push(input string name, output int at);
        bit seen;
        seen = 1'b0;
        at   = -1;
        for (int n = 0; n < 24 && !seen; n++) begin
            step();
            if (out_push != 4'd0) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        check($sformatf("%s push seen", name), 32'(seen), 32'd1);
    endtask

    function automatic logic [9:0] fw(input int i, input int j);
        logic [1:0] d;
        d  = 2'((i + j + 1) % 4);
        fw = {d, 8'(i * 16 + j)};
    endfunction

    typedef struct {
        int         src;
        logic [9:0] word;
        logic [3:0] exp_pop;
        logic [1:0] exp_grant;
        logic [3:0] exp_push;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int         at;
        int         prev_at;
        logic [9:0] w;
        logic [1:0] d;

        vecs[0] = '{src: 1, word: 10'b10_0110_0101, exp_pop: 4'b0010, exp_grant: 2'd1, exp_push: 4'b0100};
        vecs[1] = '{src: 0, word: 10'b00_1111_0000, exp_pop: 4'b0001, exp_grant: 2'd0, exp_push: 4'b0001};
        vecs[2] = '{src: 3, word: 10'b11_0000_0001, exp_pop: 4'b1000, exp_grant: 2'd3, exp_push: 4'b1000};
        vecs[3] = '{src: 2, word: 10'b01_1010_1010, exp_pop: 4'b0100, exp_grant: 2'd2, exp_push: 4'b0010};
        vecs[4] = '{src: 3, word: 10'b00_0000_0000, exp_pop: 4'b1000, exp_grant: 2'd3, exp_push: 4'b0001};

        // Reset with every FIFO empty.
        reset           = 1'b1;
        out_almost_full = 4'b0000;
        for (int r = 0; r < 2; r++) begin
            step();
            check($sformatf("rst%0d in_pop", r),   32'(in_pop),   32'd0);
            check($sformatf("rst%0d out_push", r), 32'(out_push), 32'd0);
            check($sformatf("rst%0d out_data", r), 32'(out_data), 32'd0);
            check($sformatf("rst%0d error", r),    32'(error),    32'd0);
            check($sformatf("rst%0d idle", r),     32'(idle),     32'd1);
            check($sformatf("rst%0d grant", r),    32'(grant),    32'd0);
        end
        reset = 1'b0;
        step();
        check("post-reset idle", 32'(idle), 32'd1);

        // Single-word transfers with exact cycle timing (t0 = load cycle).
        for (int v = 0; v < 5; v++) begin
            load(vecs[v].src, vecs[v].word);
            step();
            check($sformatf("v%0d t1 in_pop", v), 32'(in_pop), 32'(vecs[v].exp_pop));
            check($sformatf("v%0d t1 grant", v),  32'(grant),  32'(vecs[v].exp_grant));
            step();
            check($sformatf("v%0d t2 in_pop", v), 32'(in_pop), 32'd0);
            step();
            check($sformatf("v%0d t3 out_push", v), 32'(out_push), 32'(vecs[v].exp_push));
            check($sformatf("v%0d t3 out_data", v), 32'(out_data), 32'(vecs[v].word));
            step();
            check($sformatf("v%0d t4 idle", v),     32'(idle),     32'd1);
            check($sformatf("v%0d t4 out_push", v), 32'(out_push), 32'd0);
            check($sformatf("v%0d t4 out_data hold", v), 32'(out_data), 32'(vecs[v].word));
        end

        // Fairness: two words in each FIFO; last winner was FIFO 3, so order is 0,1,2,3,0,1,2,3.
        for (int i = 0; i < 4; i++) begin
            load(i, fw(i, 0));
            load(i, fw(i, 1));
        end
        prev_at = -1;
        for (int k = 0; k < 8; k++) begin
            wait_push($sformatf("fair%0d", k), at);
            w = fw(k % 4, k / 4);
            d = w[9:8];
            check($sformatf("fair%0d grant", k),    32'(grant),    32'(k % 4));
            check($sformatf("fair%0d out_data", k), 32'(out_data), 32'(w));
            check($sformatf("fair%0d out_push", k), 32'(out_push), 32'(4'b0001 << d));
            if (k > 0) check($sformatf("fair%0d spacing", k), 32'(at - prev_at), 32'd4);
            prev_at = at;
        end
        step();
        check("fair end idle", 32'(idle), 32'd1);

        // Backpressure on destination 3 for five cycles.
        out_almost_full = 4'b1000;
        load(2, 10'b11_0101_0101);
        step(); step(); step();
        for (int s = 0; s < 5; s++) begin
            check($sformatf("bp s%0d out_push", s), 32'(out_push), 32'd0);
            check($sformatf("bp s%0d in_pop", s),   32'(in_pop),   32'd0);
            check($sformatf("bp s%0d idle", s),     32'(idle),     32'd0);
            step();
        end
        out_almost_full = 4'b0000;
        #1;
        check("bp release out_push", 32'(out_push), 32'b1000);
        check("bp release out_data", 32'(out_data), 32'b11_0101_0101);
        step();
        check("bp done idle", 32'(idle), 32'd1);

        // Stall timeout on destination 0: error rises when the stall count reaches 16.
        out_almost_full = 4'b0001;
        load(1, 10'b00_1100_0011);
        step(); step(); step();
        for (int k = 0; k < 18; k++) begin
            check($sformatf("to s%0d error", k), 32'(error), 32'(k >= 16));
            step();
        end
        out_almost_full = 4'b0000;
        #1;
        check("to release out_push", 32'(out_push), 32'b0001);
        step();
        check("to after push error", 32'(error), 32'd1);
        check("to after push idle",  32'(idle),  32'd1);
        step(); step();
        check("to sticky error", 32'(error), 32'd1);

        // Reset while a word waits in SEND; the word is dropped.
        out_almost_full = 4'b0010;
        load(3, 10'b01_0000_1111);
        step(); step(); step();
        check("rm send out_push", 32'(out_push), 32'd0);
        check("rm send idle",     32'(idle),     32'd0);
        reset = 1'b1;
        step();
        check("rm idle",     32'(idle),     32'd1);
        check("rm out_push", 32'(out_push), 32'd0);
        check("rm error",    32'(error),    32'd0);
        check("rm out_data", 32'(out_data), 32'd0);
        check("rm grant",    32'(grant),    32'd0);
        reset           = 1'b0;
        out_almost_full = 4'b0000;
        for (int i = 0; i < 4; i++) load(i, fw(i, 2));
        step();
        check("rm first pop",   32'(in_pop), 32'b0001);
        check("rm first grant", 32'(grant),  32'd0);
        for (int k = 0; k < 4; k++) begin
            wait_push($sformatf("rm%0d", k), at);
            check($sformatf("rm%0d grant", k),    32'(grant),    32'(k));
            check($sformatf("rm%0d out_data", k), 32'(out_data), 32'(fw(k, 2)));
        end
        step();
        check("rm end idle", 32'(idle), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case a sequence above stalls unexpectedly.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
